// File: rtl/onehot_scan_encoder.sv
// Sequential set-bit encoder: captures a request vector and emits the index of each set bit,
// one per handshake beat. Optional popcount outputs are enabled by the macro SCAN_COUNT_EN.
module onehot_scan_encoder #(
  parameter int  WIDTH     = 8,
  parameter int  MSB_FIRST = 0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             empty_pulse,
  output logic             busy
`ifdef SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count,
  output logic [IDX_W:0]   out_remain
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE_VEC = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pending_r, pending_s;
  logic             empty_pulse_r, empty_s;
  logic [IDX_W-1:0] idx_s;
  logic             last_s;

  // Priority pick: the last hit of the loop wins, so the scan direction selects the order
  function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    int               b;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b = (MSB_FIRST != 0) ? i : (WIDTH - 1 - i);
      if (vec[b]) begin
        idx = IDX_W'(b);
      end
    end
    return idx;
  endfunction

`ifdef SCAN_COUNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] vec);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction
`endif

  // Index and last flag decoded from the registered pending vector only
  always_comb begin
    idx_s  = pick_idx(pending_r);
    last_s = (pending_r != '0) && ((pending_r & (pending_r - ONE_VEC)) == '0);
  end

  // Next-state, pending update and empty-capture detection
  always_comb begin
    state_s   = state_r;
    pending_s = pending_r;
    empty_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_s = in_vec;
            state_s   = SCAN;
          end else begin
            empty_s = 1'b1;
          end
        end else begin
          empty_s = 1'b0;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_s = pending_r & ~(ONE_VEC << idx_s);
          if (last_s) begin
            state_s = IDLE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = '0;
      end
    endcase
  end

  // State, pending vector and empty pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pending_r     <= '0;
      empty_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      pending_r     <= pending_s;
      empty_pulse_r <= empty_s;
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == SCAN);
  assign busy        = (state_r == SCAN);
  assign out_idx     = idx_s;
  assign out_last    = last_s;
  assign empty_pulse = empty_pulse_r;

`ifdef SCAN_COUNT_EN
  logic [IDX_W:0] count_r;

  // Popcount of the captured vector, held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if ((state_r == IDLE) && in_valid) begin
      count_r <= popcount(in_vec);
    end else begin
      count_r <= count_r;
    end
  end

  assign out_count  = count_r;
  assign out_remain = popcount(pending_r);
`endif

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Bench for onehot_scan_encoder: three instances (8/LSB, 8/MSB, 5/LSB) against an index-list model
// plus directed literal expectations. Define SCAN_COUNT_EN to also check the popcount outputs.
module tb_onehot_scan_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] in_valid, out_ready, in_ready, out_valid, out_last, empty_pulse, busy;
  logic [7:0] vec0, vec1;
  logic [4:0] vec2;
  logic [2:0] idx [3];
`ifdef SCAN_COUNT_EN
  logic [3:0] cnt [3];
  logic [3:0] rem [3];
`endif

  int checks   = 0;
  int failures = 0;

  onehot_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(vec0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_idx(idx[0]), .out_last(out_last[0]),
    .empty_pulse(empty_pulse[0]), .busy(busy[0])
`ifdef SCAN_COUNT_EN
    , .out_count(cnt[0]), .out_remain(rem[0])
`endif
  );

  onehot_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(vec1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_idx(idx[1]), .out_last(out_last[1]),
    .empty_pulse(empty_pulse[1]), .busy(busy[1])
`ifdef SCAN_COUNT_EN
    , .out_count(cnt[1]), .out_remain(rem[1])
`endif
  );

  onehot_scan_encoder #(.WIDTH(5), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_vec(vec2),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_idx(idx[2]), .out_last(out_last[2]),
    .empty_pulse(empty_pulse[2]), .busy(busy[2])
`ifdef SCAN_COUNT_EN
    , .out_count(cnt[2]), .out_remain(rem[2])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: per instance, the ordered list of indices still owed and the position in it
  int m_list [3][8];
  int m_n    [3];
  int m_pos  [3];
  int m_cnt  [3];
  bit m_empty[3];

  initial begin : model
    logic [7:0] v;
    int         w;
    int         bi;
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_empty[i] = 1'b0;
    end
    @(posedge clk);
    forever begin
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_n[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_empty[i] = 1'b0;
        end else if (m_pos[i] < m_n[i]) begin
          m_empty[i] = 1'b0;
          if (out_ready[i]) m_pos[i]++;
        end else begin
          m_empty[i] = 1'b0;
          if (in_valid[i]) begin
            v = (i == 0) ? vec0 : (i == 1) ? vec1 : {3'b000, vec2};
            w = (i == 2) ? 5 : 8;
            m_n[i]   = 0;
            m_pos[i] = 0;
            for (int b = 0; b < w; b++) begin
              bi = (i == 1) ? (w - 1 - b) : b;
              if (v[bi]) begin
                m_list[i][m_n[i]] = bi;
                m_n[i]++;
              end
            end
            m_cnt[i]   = m_n[i];
            m_empty[i] = (m_n[i] == 0);
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d_out_valid", i), out_valid[i], (m_pos[i] < m_n[i]) ? 1 : 0);
        chk($sformatf("m%0d_in_ready", i), in_ready[i], (m_pos[i] < m_n[i]) ? 0 : 1);
        chk($sformatf("m%0d_busy", i), busy[i], (m_pos[i] < m_n[i]) ? 1 : 0);
        chk($sformatf("m%0d_empty", i), empty_pulse[i], m_empty[i] ? 1 : 0);
        chk($sformatf("m%0d_last", i), out_last[i], (m_pos[i] == m_n[i] - 1) ? 1 : 0);
        if (m_pos[i] < m_n[i]) begin
          chk($sformatf("m%0d_idx", i), idx[i], m_list[i][m_pos[i]]);
        end
`ifdef SCAN_COUNT_EN
        chk($sformatf("m%0d_count", i), cnt[i], m_cnt[i]);
        chk($sformatf("m%0d_remain", i), rem[i], m_n[i] - m_pos[i]);
`endif
      end
      @(posedge clk);
    end
  end

  logic [7:0] tab8 [4];
  logic [4:0] tab5 [4];
  int         seen [8];
  int         seen_last [8];
  int         exp6 [4];
  int         nb, busy_cnt;

  initial begin
    tab8 = '{8'h81, 8'h7E, 8'h00, 8'h3C};
    tab5 = '{5'h10, 5'h00, 5'h1F, 5'h05};
    exp6 = '{0, 1, 3, 4};
    rst = 1'b1; in_valid = 3'b000; out_ready = 3'b111;
    vec0 = 8'h00; vec1 = 8'h00; vec2 = 5'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 7);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty_pulse, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx0", idx[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Single bit
    vec0 = 8'h04; in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    chk("t1_idx", idx[0], 2);
    chk("t1_last", out_last[0], 1);
    chk("t1_in_ready_scan", in_ready[0], 0);
    @(negedge clk);
    chk("t1_in_ready_after", in_ready[0], 1);
    chk("t1_valid_after", out_valid[0], 0);

    // Three bits, LSB first, busy for exactly three cycles
    vec0 = 8'hA2; in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    nb = 0; busy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy[0]) begin
        busy_cnt++;
        if (nb < 8) begin
          seen[nb] = idx[0]; seen_last[nb] = out_last[0];
        end
        nb++;
      end
      @(negedge clk);
    end
    chk("t2_busy_cycles", busy_cnt, 3);
    chk("t2_idx0", seen[0], 1);
    chk("t2_idx1", seen[1], 5);
    chk("t2_idx2", seen[2], 7);
    chk("t2_last0", seen_last[0], 0);
    chk("t2_last2", seen_last[2], 1);

    // MSB first with a stalled first beat
    out_ready[1] = 1'b0; vec1 = 8'hA2; in_valid[1] = 1'b1;
    @(negedge clk); in_valid[1] = 1'b0;
    chk("t3_idx_stall0", idx[1], 7);
    repeat (3) begin
      @(negedge clk);
      chk("t3_idx_stall", idx[1], 7);
      chk("t3_last_stall", out_last[1], 0);
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("t3_idx5", idx[1], 5);
    @(negedge clk);
    chk("t3_idx1", idx[1], 1);
    chk("t3_last1", out_last[1], 1);
    @(negedge clk);
    chk("t3_in_ready", in_ready[1], 1);

    // Zero vector
    vec0 = 8'h00; in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    chk("t4_empty", empty_pulse[0], 1);
    chk("t4_valid", out_valid[0], 0);
    chk("t4_in_ready", in_ready[0], 1);
    @(negedge clk);
    chk("t4_empty_gone", empty_pulse[0], 0);

    // Reset in the middle of a scan, then a top-bit capture
    vec0 = 8'hFF; in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    chk("t5_idx0", idx[0], 0);
    @(negedge clk); chk("t5_idx1", idx[0], 1);
    @(negedge clk); chk("t5_idx2", idx[0], 2);
    @(negedge clk); chk("t5_idx3", idx[0], 3);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_rst_valid", out_valid[0], 0);
    chk("t5_rst_in_ready", in_ready[0], 1);
    chk("t5_rst_last", out_last[0], 0);
    vec0 = 8'h80; in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    chk("t5_top_idx", idx[0], 7);
    chk("t5_top_last", out_last[0], 1);
    @(negedge clk);

    // Five-bit instance
    vec2 = 5'b11011; in_valid[2] = 1'b1;
    @(negedge clk); in_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_idx%0d", k), idx[2], exp6[k]);
      chk($sformatf("t6_last%0d", k), out_last[2], (k == 3) ? 1 : 0);
`ifdef SCAN_COUNT_EN
      chk($sformatf("t6_count%0d", k), cnt[2], 4);
      chk($sformatf("t6_remain%0d", k), rem[2], 4 - k);
`endif
      @(negedge clk);
    end
    chk("t6_done", out_valid[2], 0);

    // Continuous offers with a periodic consumer stall on all instances
    for (int t = 0; t < 4; t++) begin
      vec0 = tab8[t]; vec1 = tab8[t]; vec2 = tab5[t]; in_valid = 3'b111;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        out_ready = (c % 3 == 1) ? 3'b000 : 3'b111;
      end
    end
    in_valid = 3'b000; out_ready = 3'b111;
    repeat (12) @(negedge clk);
    chk("drain_in_ready", in_ready, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
